// File: rtl/preamble_pkg.sv
// Shared state type, default training table and windowing helper for the
// preamble sequence generator.
package preamble_pkg;

  localparam int STS_LEN = 32;
  localparam int STS_W   = 28;
  localparam int HALF_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL,
    FIN
  } state_t;

  // Real part of the 802.11a short training symbol, Q3.24, two periods of 16.
  localparam logic signed [STS_W-1:0] STS_DEFAULT [STS_LEN] = '{
    28'sd771752,  -28'sd2214593, -28'sd218104,  28'sd2399142,
    28'sd1543504, 28'sd2399142,  -28'sd218104,  -28'sd2214593,
    28'sd771752,  28'sd33554,    -28'sd1325400, -28'sd218104,
    28'sd0,       -28'sd218104,  -28'sd1325400, 28'sd33554,
    28'sd771752,  -28'sd2214593, -28'sd218104,  28'sd2399142,
    28'sd1543504, 28'sd2399142,  -28'sd218104,  -28'sd2214593,
    28'sd771752,  28'sd33554,    -28'sd1325400, -28'sd218104,
    28'sd0,       -28'sd218104,  -28'sd1325400, 28'sd33554
  };

  // Callers sign-extend into the wide argument and truncate the result.
  function automatic logic signed [HALF_W-1:0] win_half(input logic signed [HALF_W-1:0] x);
    return x >>> 1;
  endfunction

endpackage

// File: rtl/preamble_table.sv
// Programmable sample table: registers reload the default sequence on reset,
// single gated write port, combinational read port.
module preamble_table
  import preamble_pkg::*;
#(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Tables deeper than the default simply repeat it, which keeps it periodic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(STS_DEFAULT[i % STS_LEN]);
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/preamble_seq_gen.sv
// Training-sequence generator: replays the periodic table REPS times as a
// valid/ready stream, with optional half-amplitude leading and trailing edges.
module preamble_seq_gen
  import preamble_pkg::*;
#(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 32,
  parameter int REP_W  = 4,
  parameter int IDX_W  = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              SYS_CLK,
  input  logic              PHY_RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [REP_W-1:0]  REPS,
  input  logic [AW:0]       PERIOD,
  input  logic              WIN_EN,
  input  logic              CFG_WE,
  input  logic [AW-1:0]     CFG_ADDR,
  input  logic [DATA_W-1:0] CFG_DATA,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [IDX_W-1:0]  OUT_INDEX,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam longint MAX_LEN  = longint'(2**REP_W - 1) * longint'(DEPTH) + 1;
  localparam longint IDX_SPAN = longint'(1) << IDX_W;

  if (((DEPTH & (DEPTH - 1)) != 0) || (IDX_SPAN <= MAX_LEN)) begin : g_bad_params
    $error("preamble_seq_gen: DEPTH must be a power of two and IDX_W must cover the longest burst");
  end

  state_t            state;
  logic [AW-1:0]     s_cnt;
  logic [REP_W-1:0]  r_cnt;
  logic [REP_W-1:0]  reps_q;
  logic [AW:0]       period_q;
  logic              win_q;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] tbl_data;
  logic [DATA_W-1:0] tbl_half;
  logic              load;
  logic              wrap;
  logic              final_sample;
  logic              cfg_we_gated;

  assign cfg_we_gated = CFG_WE && (state == IDLE);

  // The sample counter is back at 0 after the final wrap, so TAIL reads entry 0 here too.
  preamble_table #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk    (SYS_CLK),
    .rst_n  (PHY_RST_N),
    .we     (cfg_we_gated),
    .wr_addr(CFG_ADDR),
    .wr_data(CFG_DATA),
    .rd_addr(s_cnt),
    .rd_data(tbl_data)
  );

  assign tbl_half     = DATA_W'(win_half(HALF_W'(signed'(tbl_data))));
  assign load         = !OUT_VALID || OUT_READY;
  assign wrap         = ({1'b0, s_cnt} == (period_q - (AW+1)'(1)));
  assign final_sample = wrap && (r_cnt == (reps_q - REP_W'(1)));
  assign BUSY         = (state != IDLE);

  always_ff @(posedge SYS_CLK or negedge PHY_RST_N) begin
    if (!PHY_RST_N) begin
      state     <= IDLE;
      s_cnt     <= '0;
      r_cnt     <= '0;
      reps_q    <= '0;
      period_q  <= '0;
      win_q     <= 1'b0;
      idx       <= '0;
      OUT_DATA  <= '0;
      OUT_INDEX <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (ABORT) begin
        state     <= IDLE;
        s_cnt     <= '0;
        r_cnt     <= '0;
        reps_q    <= '0;
        period_q  <= '0;
        win_q     <= 1'b0;
        idx       <= '0;
        OUT_VALID <= 1'b0;
        OUT_LAST  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (START) begin
              reps_q   <= REPS;
              period_q <= PERIOD;
              win_q    <= WIN_EN;
              s_cnt    <= '0;
              r_cnt    <= '0;
              idx      <= '0;
              state    <= ((REPS == '0) || (PERIOD == '0)) ? FIN : RUN;
            end
          end
          RUN: begin
            if (load) begin
              OUT_DATA  <= (win_q && (idx == '0)) ? tbl_half : tbl_data;
              OUT_INDEX <= idx;
              OUT_VALID <= 1'b1;
              OUT_LAST  <= final_sample && !win_q;
              idx       <= idx + IDX_W'(1);
              if (wrap) begin
                s_cnt <= '0;
                r_cnt <= r_cnt + REP_W'(1);
              end else begin
                s_cnt <= s_cnt + AW'(1);
              end
              if (final_sample) begin
                state <= win_q ? TAIL : FIN;
              end
            end
          end
          TAIL: begin
            if (load) begin
              OUT_DATA  <= tbl_half;
              OUT_INDEX <= idx;
              OUT_VALID <= 1'b1;
              OUT_LAST  <= 1'b1;
              idx       <= idx + IDX_W'(1);
              state     <= FIN;
            end
          end
          FIN: begin
            // A load here means the final sample (if any) has just been taken.
            if (load) begin
              OUT_VALID <= 1'b0;
              OUT_LAST  <= 1'b0;
              DONE      <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/preamble_seq_gen.md
# preamble_seq_gen

Parametrised training-sequence generator for the DMT/VLC PHY transmitter: replays a programmable periodic table a run-time number of times. Optional raised-edge windowing halves the first sample and appends a halved trailing sample. Output is a valid/ready stream, so the sample mux or IFFT path can stall it. Sits between the PHY control FSM (START/DONE) and the transmit sample mux; covers the short preamble by default and any other periodic preamble once reprogrammed.

## Interface
- DATA_W, 28: sample width, two's complement (1 sign, 3 integer, DATA_W-4 fractional).
- DEPTH, 32: table entries, power of two; AW = clog2(DEPTH).
- REP_W, 4: width of the repetition count.
- IDX_W, 9: sample index width; must satisfy 2^IDX_W > (2^REP_W-1)*DEPTH+1 (elaboration check).
- SYS_CLK  in  1  clock; all logic on rising edge.
- PHY_RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; honoured only in IDLE.
- ABORT  in  1  synchronous cancel; priority over everything except reset.
- REPS  in  REP_W  periods to send; latched on accepted START.
- PERIOD  in  AW+1  samples per period, 0..DEPTH; latched on accepted START.
- WIN_EN  in  1  windowing enable; latched on accepted START.
- CFG_WE  in  1  table write strobe; ignored unless IDLE.
- CFG_ADDR  in  AW  table write address.
- CFG_DATA  in  DATA_W  table write data.
- OUT_DATA  out  DATA_W  sample.
- OUT_INDEX  out  IDX_W  sample number within the burst, 0 first.
- OUT_VALID  out  1  OUT_DATA/OUT_INDEX/OUT_LAST valid.
- OUT_READY  in  1  downstream accepts when OUT_VALID && OUT_READY.
- OUT_LAST  out  1  marks the final sample of a burst.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse after the last sample is accepted.

## Operation
- States: IDLE, RUN, TAIL, FIN.
- IDLE: START latches REPS/PERIOD/WIN_EN. Go to FIN if REPS==0 or PERIOD==0; otherwise go to RUN with sample counter s=0 and period counter r=0.
- RUN: each time the output register loads, it takes table[s]. s wraps at PERIOD-1, and r increments on each wrap.
  - After sample (REPS-1, PERIOD-1), go to TAIL if WIN_EN, else go to FIN.
- TAIL: loads one sample, table[0] >>> 1 (arithmetic shift, rounds toward -inf), then goes to FIN.
- FIN: waits until the final sample is accepted, pulses DONE for one cycle, then returns to IDLE.
- Windowing: with WIN_EN, burst sample 0 is table[0] >>> 1. All other RUN samples pass unchanged.
- Burst length: REPS*PERIOD + WIN_EN samples. OUT_INDEX counts 0..length-1; OUT_LAST is set only on the final sample.
- Table: DEPTH x DATA_W registers. Reset loads the package default, the 802.11a short training sequence (16-periodic, 32 entries). CFG writes are accepted only in IDLE; writes while BUSY are dropped.
- ABORT: next cycle OUT_VALID=0 and state=IDLE; no DONE pulse; latched parameters are discarded.
- START while BUSY is ignored.
- START and CFG_WE in the same IDLE cycle: the write lands, and the burst reads the new value.

## Timing
- Reset values: OUT_DATA=0, OUT_INDEX=0, OUT_VALID=0, OUT_LAST=0, BUSY=0, DONE=0, state=IDLE, all counters 0, table=default.
- START accepted at edge t: BUSY=1 and OUT_VALID=1 carrying sample 0 after edge t+1.
- Output register loads when !OUT_VALID || OUT_READY. With OUT_READY held high, one sample per cycle, no bubbles, including across period wraps and into TAIL.
- Stall: while OUT_VALID && !OUT_READY, OUT_DATA/OUT_INDEX/OUT_LAST hold stable and the counters freeze.
- DONE: asserted the cycle after the last handshake; BUSY drops in that same cycle. Earliest re-START is in the DONE cycle.
- Degenerate burst (REPS==0 or PERIOD==0): DONE one cycle after START acceptance, no OUT_VALID.
- Reset mid-burst: outputs return to reset values immediately (asynchronous).

## Structure
- Package preamble_pkg holds:
  - STS_DEFAULT (32 x 28-bit constant array);
  - the state enum;
  - a function win_half(x), returning the arithmetic right shift by 1.
- One sub-module, preamble_table: the register array with async-reset default load and the gated write port, plus a combinational read port.
- The FSM, counters and output skid register live in the top level.

## Test plan
- Default table, REPS=10, PERIOD=16, WIN_EN=1, OUT_READY=1 -> 161 contiguous samples.
  - Index 0 = STS_DEFAULT[0]>>>1; index 1 = STS_DEFAULT[1]; index 16 = STS_DEFAULT[0].
  - Index 160 = STS_DEFAULT[0]>>>1 with OUT_LAST=1; DONE pulses the following cycle.
- Same burst, WIN_EN=0 -> 160 samples; index 0 is unhalved; OUT_LAST on index 159 = STS_DEFAULT[15].
- OUT_READY toggled by a random 50% pattern -> accepted sequence identical to the free-running case; no drop or duplicate; data stable during stalls.
- CFG write addr 3 = 28'h8000001 in IDLE, then REPS=1, PERIOD=4, WIN_EN=1:
  - index 3 = 28'h8000001; index 4 = STS_DEFAULT[0]>>>1.
  - A CFG write issued mid-burst is dropped, confirmed by a second burst.
- ABORT asserted at index 37 of a 161-sample burst -> OUT_VALID=0 next cycle, no DONE; a new START then begins at index 0.
- REPS=0 -> DONE one cycle after START with no valid samples.
- PHY_RST_N pulsed low mid-burst -> all outputs 0 immediately; table restored to default.
